// File: rtl/spi_apb_cmd_master_if.sv
// Bundle of the request/response stream and the APB3 bus around
// spi_apb_cmd_master.
//   req_*   : sequencer -> master request (valid/ready)
//   rsp_*   : master -> sequencer response (valid/ready)
//   P*      : APB3 initiator signals towards the SPI peripheral
//   busy    : master is not idle
// modport master = DUT view, modport slave = environment view.
interface spi_apb_cmd_master_if #(
  parameter int APB_ADDR_WIDTH = 12
);
  logic                      req_valid;
  logic                      req_ready;
  logic [APB_ADDR_WIDTH-1:0] req_addr;
  logic [31:0]               req_wdata;
  logic                      req_write;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [31:0]               rsp_rdata;
  logic                      rsp_err;
  logic                      rsp_timeout;
  logic [APB_ADDR_WIDTH-1:0] PADDR;
  logic [31:0]               PWDATA;
  logic                      PWRITE;
  logic                      PSEL;
  logic                      PENABLE;
  logic [31:0]               PRDATA;
  logic                      PREADY;
  logic                      PSLVERR;
  logic                      busy;

  modport master (
    input  req_valid, req_addr, req_wdata, req_write, rsp_ready,
           PRDATA, PREADY, PSLVERR,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           PADDR, PWDATA, PWRITE, PSEL, PENABLE, busy
  );

  modport slave (
    output req_valid, req_addr, req_wdata, req_write, rsp_ready,
           PRDATA, PREADY, PSLVERR,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           PADDR, PWDATA, PWRITE, PSEL, PENABLE, busy
  );
endinterface

// File: rtl/spi_apb_cmd_master.sv
// APB3 initiator for the SPI master register block. Converts a valid/ready
// request stream into single APB transfers and returns one response per
// request. A PREADY timeout ends a stalled transfer with rsp_err/rsp_timeout.
// Ports:
//   HCLK   : clock, rising edge
//   HRESET : asynchronous active-high reset
//   bus    : spi_apb_cmd_master_if.master (request, response, APB, busy)
module spi_apb_cmd_master #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic                  HCLK,
  input logic                  HRESET,
  spi_apb_cmd_master_if.master bus
);
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CW-1:0] TO_LAST = TO_EN ? CW'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t                    state;
  logic [CW-1:0]             cnt;
  logic [APB_ADDR_WIDTH-1:0] paddr;
  logic [31:0]               pwdata, rdata;
  logic                      pwrite, psel, penable, rsp_valid, err, tmo, busy;
  logic                      timeout_hit;

  // cnt counts completed wait cycles in ACCESS; the last allowed one expires
  assign timeout_hit = TO_EN && (cnt == TO_LAST);

  // Depends on state and rsp_ready only, never on req_valid
  assign bus.req_ready   = (state == IDLE) | ((state == RESP) & bus.rsp_ready);
  assign bus.PADDR       = paddr;
  assign bus.PWDATA      = pwdata;
  assign bus.PWRITE      = pwrite;
  assign bus.PSEL        = psel;
  assign bus.PENABLE     = penable;
  assign bus.rsp_valid   = rsp_valid;
  assign bus.rsp_rdata   = rdata;
  assign bus.rsp_err     = err;
  assign bus.rsp_timeout = tmo;
  assign bus.busy        = busy;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state     <= IDLE;
      cnt       <= '0;
      paddr     <= '0;
      pwdata    <= '0;
      pwrite    <= 1'b0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      rsp_valid <= 1'b0;
      rdata     <= '0;
      err       <= 1'b0;
      tmo       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.req_valid) begin
          paddr  <= bus.req_addr;
          pwdata <= bus.req_wdata;
          pwrite <= bus.req_write;
          psel   <= 1'b1;
          busy   <= 1'b1;
          state  <= SETUP;
        end
        SETUP: begin
          penable <= 1'b1;
          cnt     <= '0;
          state   <= ACCESS;
        end
        ACCESS: begin
          // A ready slave wins over an expiring timeout in the same cycle
          if (bus.PREADY) begin
            rdata     <= pwrite ? 32'h0 : bus.PRDATA;
            err       <= bus.PSLVERR;
            tmo       <= 1'b0;
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else if (timeout_hit) begin
            rdata     <= 32'h0;
            err       <= 1'b1;
            tmo       <= 1'b1;
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: if (bus.rsp_ready) begin
          rsp_valid <= 1'b0;
          if (bus.req_valid) begin
            // back-to-back: next request goes straight to SETUP
            paddr  <= bus.req_addr;
            pwdata <= bus.req_wdata;
            pwrite <= bus.req_write;
            psel   <= 1'b1;
            state  <= SETUP;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_apb_cmd_master.sv
// Scoreboard bench for spi_apb_cmd_master (TIMEOUT_CYCLES=4).
module tb_spi_apb_cmd_master;
  localparam int AW = 12;
  localparam int T  = 4;

  logic HCLK = 1'b0;
  logic HRESET;
  always #5 HCLK = ~HCLK;

  spi_apb_cmd_master_if #(.APB_ADDR_WIDTH(AW)) ifc ();

  spi_apb_cmd_master #(.APB_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(T)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .bus(ifc.master)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic          write;
    logic [31:0]   rdata;
    logic          err;
    logic          to;
    int            acc;
    int            acc_cyc;
    bit            seen;
  } exp_t;

  typedef struct {
    int          wt;
    logic [31:0] data;
    logic        err;
  } plan_t;

  exp_t  exp_q[$];
  plan_t plan_q[$];
  int errors = 0, checks = 0, cyc = 0;
  int last_rsp_cyc = 0;
  int hold_left = 0;
  bit rr_rand = 1'b0;

  always @(posedge HCLK) cyc <= cyc + 1;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: a slave ready after wt wait states completes if that fits in
  // T ACCESS cycles, otherwise the transfer times out after exactly T.
  function automatic exp_t model(logic [AW-1:0] addr, logic [31:0] wdata,
                                 logic write, plan_t p);
    exp_t e;
    e.addr = addr; e.wdata = wdata; e.write = write; e.seen = 0; e.acc_cyc = 0;
    if (p.wt < T) begin
      e.rdata = write ? 32'h0 : p.data;
      e.err   = p.err;
      e.to    = 1'b0;
      e.acc   = p.wt + 1;
    end else begin
      e.rdata = 32'h0;
      e.err   = 1'b1;
      e.to    = 1'b1;
      e.acc   = T;
    end
    return e;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic issue(input logic [AW-1:0] addr, input logic [31:0] wdata,
                       input logic write, input int wt, input logic [31:0] data,
                       input logic err, output int acc_cyc);
    plan_t p;
    exp_t  e;
    int    n;
    p.wt = wt; p.data = data; p.err = err;
    plan_q.push_back(p);
    ifc.req_addr  = addr;
    ifc.req_wdata = wdata;
    ifc.req_write = write;
    ifc.req_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge HCLK);
      if (ifc.req_ready) break;
      n++;
      if (n > 200) begin
        errors++; checks++;
        $display("FAIL accept_timeout: got no req_ready expected accept within 200 cycles");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "request never accepted");
      end
    end
    e = model(addr, wdata, write, p);
    e.acc_cyc = cyc;
    acc_cyc = cyc;
    exp_q.push_back(e);
    @(posedge HCLK); #1;
    ifc.req_valid = 1'b0;
    ifc.req_addr  = AW'($urandom);
    ifc.req_wdata = $urandom;
    ifc.req_write = 1'($urandom_range(0, 1));
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 300) begin
      @(posedge HCLK);
      n++;
    end
    #1;
    checks++;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending responses expected 0", exp_q.size());
    end
  endtask

  // APB slave: PREADY after the planned number of wait states; garbage on
  // PRDATA/PSLVERR/PREADY whenever the master must ignore them.
  initial begin
    plan_t cur;
    bit    have = 0;
    int    k = 0;
    cur.wt = 0; cur.data = 0; cur.err = 0;
    ifc.PREADY = 0; ifc.PRDATA = 0; ifc.PSLVERR = 0;
    forever begin
      @(posedge HCLK); #1;
      if (ifc.PSEL && ifc.PENABLE) begin
        if (!have) begin
          if (plan_q.size() > 0) cur = plan_q.pop_front();
          have = 1; k = 0;
        end
        ifc.PREADY  = (k == cur.wt);
        ifc.PRDATA  = ifc.PREADY ? cur.data : $urandom;
        ifc.PSLVERR = ifc.PREADY ? cur.err : 1'($urandom_range(0, 1));
        k++;
      end else begin
        have = 0;
        ifc.PREADY  = 1'($urandom_range(0, 1));
        ifc.PRDATA  = $urandom;
        ifc.PSLVERR = 1'($urandom_range(0, 1));
      end
    end
  end

  // Response consumer
  initial begin
    ifc.rsp_ready = 1'b1;
    forever begin
      @(posedge HCLK); #1;
      if (hold_left > 0 && ifc.rsp_valid) begin
        ifc.rsp_ready = 1'b0;
        hold_left--;
      end else if (rr_rand) ifc.rsp_ready = ($urandom_range(0, 3) != 0);
      else ifc.rsp_ready = 1'b1;
    end
  end

  // Monitor / scoreboard
  initial begin
    int acc_n = 0, sel_n = 0;
    exp_t e;
    forever begin
      @(negedge HCLK);
      if (HRESET) begin
        acc_n = 0; sel_n = 0;
      end else begin
        if (ifc.PENABLE) chk("penable_needs_psel", ifc.PSEL, 1);
        if (ifc.PSEL) begin
          sel_n++;
          chk("req_ready_in_xfer", ifc.req_ready, 0);
          if (exp_q.size() > 0) begin
            chk("paddr", ifc.PADDR, exp_q[0].addr);
            chk("pwdata", ifc.PWDATA, exp_q[0].wdata);
            chk("pwrite", ifc.PWRITE, exp_q[0].write);
          end
        end
        if (ifc.PSEL && ifc.PENABLE) acc_n++;
        if (ifc.rsp_valid) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response");
          end else begin
            e = exp_q[0];
            chk("rsp_rdata", ifc.rsp_rdata, e.rdata);
            chk("rsp_err", ifc.rsp_err, e.err);
            chk("rsp_timeout", ifc.rsp_timeout, e.to);
            chk("psel_in_resp", ifc.PSEL, 0);
            if (!e.seen) begin
              chk("access_cycles", acc_n, e.acc);
              chk("psel_cycles", sel_n, e.acc + 1);
              chk("rsp_latency", cyc, e.acc_cyc + 2 + e.acc);
              exp_q[0].seen = 1;
              last_rsp_cyc = cyc;
              acc_n = 0; sel_n = 0;
            end
            if (!ifc.rsp_ready) chk("req_ready_backpressure", ifc.req_ready, 0);
            else void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    int a, b, c;
    HRESET = 1'b1;
    ifc.req_valid = 0; ifc.req_addr = 0; ifc.req_wdata = 0; ifc.req_write = 0;
    #12;
    chk("reset_ctrl", {ifc.PSEL, ifc.PENABLE, ifc.rsp_valid, ifc.busy, ifc.PWRITE,
                       ifc.rsp_err, ifc.rsp_timeout}, 0);
    chk("reset_paddr", ifc.PADDR, 0);
    chk("reset_pwdata", ifc.PWDATA, 0);
    chk("reset_rdata", ifc.rsp_rdata, 0);
    chk("reset_req_ready", ifc.req_ready, 1);
    #5 HRESET = 1'b0;
    @(posedge HCLK); #1;

    // CLKDIV write, zero wait; RXFIFO read with 3 wait states (last ACCESS cycle)
    issue(12'h004, 32'h0000_0010, 1, 0, 32'h0, 0, a);
    issue(12'h020, 32'h1111_2222, 0, 3, 32'hDEAD_BEEF, 0, a);
    drain();

    // slave error, then 5 cycles of response backpressure with a pending request
    hold_left = 5;
    issue(12'h00C, 32'h0, 0, 0, 32'h1234_5678, 1, a);
    issue(12'h010, 32'h0000_0055, 1, 0, 32'h0, 0, b);
    chk("bp_accept_cycle", b, last_rsp_cyc + 5);
    drain();

    // timeout, and PREADY on the final allowed ACCESS cycle
    issue(12'h024, 32'h0, 0, 8, 32'hCAFE_0000, 0, a);
    issue(12'h028, 32'h0, 0, 3, 32'h0BAD_F00D, 1, a);
    drain();

    // three back-to-back TXFIFO writes
    issue(12'h018, 32'hA1, 1, 0, 32'h0, 0, a);
    issue(12'h018, 32'hA2, 1, 0, 32'h0, 0, b);
    issue(12'h018, 32'hA3, 1, 0, 32'h0, 0, c);
    chk("b2b_period_1", b - a, 3);
    chk("b2b_period_2", c - b, 3);
    drain();

    // asynchronous reset in the middle of ACCESS
    issue(12'h030, 32'h0, 0, 10, 32'h5555_AAAA, 0, a);
    @(posedge HCLK); #1;
    chk("penable_before_reset", ifc.PENABLE, 1);
    #2 HRESET = 1'b1;
    #1;
    chk("async_reset_ctrl", {ifc.PSEL, ifc.PENABLE, ifc.rsp_valid, ifc.busy}, 0);
    chk("async_reset_req_ready", ifc.req_ready, 1);
    exp_q.delete();
    plan_q.delete();
    #3 HRESET = 1'b0;
    repeat (8) @(posedge HCLK);
    #1;
    issue(12'h000, 32'h0, 0, 1, 32'h8000_0001, 0, a);
    drain();

    // randomized traffic with random response backpressure
    rr_rand = 1'b1;
    for (int i = 0; i < 40; i++) begin
      int gap = $urandom_range(0, 2);
      repeat (gap) begin @(posedge HCLK); #1; end
      issue(AW'($urandom_range(0, 15) * 4), $urandom, 1'($urandom_range(0, 1)),
            $urandom_range(0, 5), $urandom, 1'($urandom_range(0, 1)), a);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
